// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding-request memory FSM feeding a 2-entry
// instruction queue. Define FETCH_ALIGN_CHECK_EN to turn misaligned PCs into adel entries.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        ireq_data_ok,
    input  logic [31:0] ireq_data,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        fetch_adel,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] pc_q, pc_d;
    logic        ireq_valid_q, ireq_valid_d;
    logic [31:0] ireq_addr_q, ireq_addr_d;

    logic [31:0] q_instr_q [2];
    logic [31:0] q_pc_q    [2];
    logic        rd_q, rd_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        pop;
    logic        data_push;
    logic        adel_push;
    logic        push;
    logic        want_issue;
    logic        wr_idx;
    logic [1:0]  cnt_mid;
    logic [1:0]  cnt_pre;
    logic [31:0] issue_addr;
    logic [31:0] push_instr;
    logic [31:0] push_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        q_adel_q [2];
    logic        halt_q, halt_d;
`endif

    always_comb begin
        pop        = (cnt_q != 2'd0) && fetch_ready;
        rd_d       = rd_q ^ pop;
        // A redirect flushes whatever survives this cycle's pop.
        cnt_mid    = redirect_valid ? 2'd0 : (cnt_q - {1'b0, pop});
        data_push  = (state_q == S_WAIT) && ireq_data_ok && !drop_q && !redirect_valid;
        cnt_pre    = cnt_mid + {1'b0, data_push};
        issue_addr = redirect_valid ? redirect_pc : pc_q;

        state_d      = state_q;
        drop_d       = drop_q;
        pc_d         = issue_addr;
        ireq_valid_d = ireq_valid_q;
        ireq_addr_d  = ireq_addr_q;
        want_issue   = 1'b0;
        adel_push    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        halt_d       = halt_q && !redirect_valid;
`endif

        unique case (state_q)
            S_IDLE: want_issue = 1'b1;
            S_REQ: begin
                // The held request can't be withdrawn; mark its response stale instead.
                if (redirect_valid) drop_d = 1'b1;
                if (ireq_addr_ok) begin
                    state_d      = S_WAIT;
                    ireq_valid_d = 1'b0;
                    if (!drop_q && !redirect_valid) pc_d = pc_q + 32'd4;
                end
            end
            S_WAIT: begin
                if (ireq_data_ok) begin
                    drop_d     = 1'b0;
                    state_d    = S_IDLE;
                    want_issue = 1'b1;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FETCH_ALIGN_CHECK_EN
        if (want_issue && (cnt_pre < 2'd2) && !halt_d) begin
            if (issue_addr[1:0] != 2'b00) begin
                adel_push = 1'b1;
                halt_d    = 1'b1;
            end else begin
                state_d      = S_REQ;
                ireq_valid_d = 1'b1;
                ireq_addr_d  = issue_addr;
            end
        end
`else
        if (want_issue && (cnt_pre < 2'd2)) begin
            state_d      = S_REQ;
            ireq_valid_d = 1'b1;
            ireq_addr_d  = issue_addr;
        end
`endif

        push       = data_push || adel_push;
        push_instr = data_push ? ireq_data : 32'd0;
        push_pc    = data_push ? ireq_addr_q : issue_addr;
        wr_idx     = rd_d ^ cnt_mid[0];
        cnt_d      = cnt_mid + {1'b0, push};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            drop_q       <= 1'b0;
            pc_q         <= RESET_PC;
            ireq_valid_q <= 1'b0;
            ireq_addr_q  <= RESET_PC;
            rd_q         <= 1'b0;
            cnt_q        <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_instr_q[i] <= 32'd0;
                q_pc_q[i]    <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
                q_adel_q[i]  <= 1'b0;
`endif
            end
`ifdef FETCH_ALIGN_CHECK_EN
            halt_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            pc_q         <= pc_d;
            ireq_valid_q <= ireq_valid_d;
            ireq_addr_q  <= ireq_addr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            if (push) begin
                q_instr_q[wr_idx] <= push_instr;
                q_pc_q[wr_idx]    <= push_pc;
`ifdef FETCH_ALIGN_CHECK_EN
                q_adel_q[wr_idx]  <= adel_push;
`endif
            end
`ifdef FETCH_ALIGN_CHECK_EN
            halt_q       <= halt_d;
`endif
        end
    end

    assign ireq_valid  = ireq_valid_q;
    assign ireq_addr   = ireq_addr_q;
    assign fetch_valid = (cnt_q != 2'd0);
    assign fetch_instr = q_instr_q[rd_q];
    assign fetch_pc    = q_pc_q[rd_q];
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_adel  = fetch_valid && q_adel_q[rd_q];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, reset/alignment sequences, and a
// randomized run against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        ireq_data_ok;
    logic [31:0] ireq_data;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_adel;
`endif

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_addr_ok   (ireq_addr_ok),
        .ireq_data_ok   (ireq_data_ok),
        .ireq_data      (ireq_data),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetch_adel     (fetch_adel),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic aok, input logic dok, input logic [31:0] d,
                         input logic rdy, input logic rd, input logic [31:0] rp);
        ireq_addr_ok   = aok;
        ireq_data_ok   = dok;
        ireq_data      = d;
        fetch_ready    = rdy;
        redirect_valid = rd;
        redirect_pc    = rp;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ivalid"}, {31'd0, ireq_valid}, 32'd0);
        chk({tag, "_iaddr"}, ireq_addr, RST_PC);
        chk({tag, "_fvalid"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_fpc"}, fetch_pc, 32'd0);
        chk({tag, "_finstr"}, fetch_instr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk({tag, "_adel"}, {31'd0, fetch_adel}, 32'd0);
`endif
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        resetn = 1'b1;
    endtask

    // Directed table: expected outputs seen before this row's inputs are applied.
    typedef struct packed {
        logic        e_iv;
        logic [31:0] e_ia;
        logic        e_fv;
        logic [31:0] e_fpc;
        logic [31:0] e_fi;
        logic        aok;
        logic        dok;
        logic [31:0] data;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
    } row_t;

    row_t tbl [22];

    function automatic row_t mk(input logic e_iv, input logic [31:0] e_ia, input logic e_fv,
                                input logic [31:0] e_fpc, input logic [31:0] e_fi,
                                input logic aok, input logic dok, input logic [31:0] data,
                                input logic rdy, input logic rd, input logic [31:0] rpc);
        row_t r;
        r.e_iv = e_iv; r.e_ia = e_ia; r.e_fv = e_fv; r.e_fpc = e_fpc; r.e_fi = e_fi;
        r.aok = aok; r.dok = dok; r.data = data; r.rdy = rdy; r.rd = rd; r.rpc = rpc;
        return r;
    endfunction

    task automatic apply_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            chk($sformatf("row%0d_ivalid", i), {31'd0, ireq_valid}, {31'd0, tbl[i].e_iv});
            if (tbl[i].e_iv || i == 0) chk($sformatf("row%0d_iaddr", i), ireq_addr, tbl[i].e_ia);
            chk($sformatf("row%0d_fvalid", i), {31'd0, fetch_valid}, {31'd0, tbl[i].e_fv});
            if (tbl[i].e_fv) begin
                chk($sformatf("row%0d_fpc", i), fetch_pc, tbl[i].e_fpc);
                chk($sformatf("row%0d_finstr", i), fetch_instr, tbl[i].e_fi);
            end
            drive(tbl[i].aok, tbl[i].dok, tbl[i].data, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
            @(negedge clk);
        end
    endtask

    // Reference model: queue of fetched entries plus one outstanding request.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    int          m_ph;
    logic        m_stale;
    logic [31:0] m_pc;
    logic [31:0] m_addr;

    task automatic model_reset();
        m_q.delete();
        m_ph = 0; m_stale = 1'b0; m_pc = RST_PC; m_addr = RST_PC;
    endtask

    task automatic model_step(input logic aok, input logic dok, input logic [31:0] d,
                              input logic rdy, input logic rd, input logic [31:0] rp);
        bit   free;
        ent_t e;
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (rd) m_q.delete();
        free = 1'b0;
        case (m_ph)
            0: free = 1'b1;
            1: if (aok) begin
                m_ph = 2;
                if (!m_stale) m_pc = m_pc + 32'd4;
            end
            default: if (dok) begin
                if (!m_stale && !rd) begin
                    e.instr = d;
                    e.pc    = m_addr;
                    m_q.push_back(e);
                end
                m_stale = 1'b0;
                m_ph    = 0;
                free    = 1'b1;
            end
        endcase
        if (rd) begin
            m_pc = rp;
            if (!free) m_stale = 1'b1;
        end
        if (free && m_q.size() < 2) begin
            m_ph   = 1;
            m_addr = m_pc;
        end
    endtask

    initial begin
        tbl[0]  = mk(0, RST_PC,        0, 0, 0,                     0, 0, 32'h0,        0, 0, 32'h0);
        tbl[1]  = mk(1, RST_PC,        0, 0, 0,                     1, 0, 32'h0,        0, 0, 32'h0);
        tbl[2]  = mk(0, 32'h0,         0, 0, 0,                     0, 1, 32'h2408_0001, 0, 0, 32'h0);
        tbl[3]  = mk(1, 32'hBFC0_0004, 1, RST_PC, 32'h2408_0001,    1, 0, 32'h0,        0, 0, 32'h0);
        tbl[4]  = mk(0, 32'h0,         1, RST_PC, 32'h2408_0001,    0, 1, 32'h1111_1111, 0, 0, 32'h0);
        tbl[5]  = mk(0, 32'h0,         1, RST_PC, 32'h2408_0001,    0, 1, 32'hEEEE_EEEE, 0, 0, 32'h0);
        tbl[6]  = mk(0, 32'h0,         1, RST_PC, 32'h2408_0001,    0, 0, 32'h0,        0, 0, 32'h0);
        tbl[7]  = mk(0, 32'h0,         1, RST_PC, 32'h2408_0001,    0, 0, 32'h0,        1, 0, 32'h0);
        tbl[8]  = mk(1, 32'hBFC0_0008, 1, 32'hBFC0_0004, 32'h1111_1111, 1, 0, 32'h0,    0, 0, 32'h0);
        tbl[9]  = mk(0, 32'h0,         1, 32'hBFC0_0004, 32'h1111_1111, 0, 0, 32'h0,    0, 1, 32'h8000_1000);
        tbl[10] = mk(0, 32'h0,         0, 0, 0,                     0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        tbl[11] = mk(1, 32'h8000_1000, 0, 0, 0,                     1, 0, 32'h0,        0, 0, 32'h0);
        tbl[12] = mk(0, 32'h0,         0, 0, 0,                     0, 1, 32'hAAAA_0001, 0, 0, 32'h0);
        tbl[13] = mk(1, 32'h8000_1004, 1, 32'h8000_1000, 32'hAAAA_0001, 1, 0, 32'h0,    0, 0, 32'h0);
        tbl[14] = mk(0, 32'h0,         1, 32'h8000_1000, 32'hAAAA_0001, 0, 1, 32'hBBBB_0002, 1, 1, 32'h8000_2000);
        tbl[15] = mk(1, 32'h8000_2000, 0, 0, 0,                     0, 1, 32'h9999_9999, 0, 0, 32'h0);
        tbl[16] = mk(1, 32'h8000_2000, 0, 0, 0,                     0, 0, 32'h0,        0, 1, 32'h8000_3000);
        tbl[17] = mk(1, 32'h8000_2000, 0, 0, 0,                     1, 0, 32'h0,        0, 0, 32'h0);
        tbl[18] = mk(0, 32'h0,         0, 0, 0,                     0, 1, 32'hCCCC_0003, 0, 0, 32'h0);
        tbl[19] = mk(1, 32'h8000_3000, 0, 0, 0,                     1, 0, 32'h0,        0, 0, 32'h0);
        tbl[20] = mk(0, 32'h0,         0, 0, 0,                     0, 1, 32'hDDDD_0004, 0, 0, 32'h0);
        tbl[21] = mk(1, 32'h8000_3004, 1, 32'h8000_3000, 32'hDDDD_0004, 0, 0, 32'h0,    0, 0, 32'h0);

        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        do_reset();
        apply_rows(0, 21);

        // Reset pulsed while a request is in WAIT with one entry queued.
        do_reset();
        apply_rows(0, 3);
        #2 resetn = 1'b0;
        #1 chk_reset_outputs("midrst");
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk_reset_outputs("inrst");
        resetn = 1'b1;
        @(negedge clk);
        chk("postrst_ivalid", {31'd0, ireq_valid}, 32'd1);
        chk("postrst_iaddr", ireq_addr, RST_PC);
        chk("postrst_fvalid0", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        chk("postrst_fvalid1", {31'd0, fetch_valid}, 32'd0);
        chk("postrst_iaddr_hold", ireq_addr, RST_PC);

`ifdef FETCH_ALIGN_CHECK_EN
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_0002);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("adel_ivalid", {31'd0, ireq_valid}, 32'd0);
            chk("adel_fvalid", {31'd0, fetch_valid}, 32'd1);
            chk("adel_flag", {31'd0, fetch_adel}, 32'd1);
            chk("adel_fpc", fetch_pc, 32'h8000_0002);
            chk("adel_finstr", fetch_instr, 32'd0);
            @(negedge clk);
        end
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        aok, dok, rdy, rd;
            logic [31:0] d, rp;
            chk("rnd_ivalid", {31'd0, ireq_valid}, {31'd0, (m_ph == 1)});
            if (m_ph == 1) chk("rnd_iaddr", ireq_addr, m_addr);
            chk("rnd_fvalid", {31'd0, fetch_valid}, {31'd0, (m_q.size() != 0)});
            if (m_q.size() != 0) begin
                chk("rnd_fpc", fetch_pc, m_q[0].pc);
                chk("rnd_finstr", fetch_instr, m_q[0].instr);
`ifdef FETCH_ALIGN_CHECK_EN
                chk("rnd_adel", {31'd0, fetch_adel}, 32'd0);
`endif
            end
            aok = ($urandom_range(0, 1) == 1);
            dok = (m_ph == 2) ? ($urandom_range(0, 4) < 3) : ($urandom_range(0, 9) == 0);
            d   = $urandom;
            rdy = ($urandom_range(0, 1) == 1);
            rd  = ($urandom_range(0, 11) == 0);
            rp  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            drive(aok, dok, d, rdy, rd, rp);
            model_step(aok, dok, d, rdy, rd, rp);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port ireq_valid, output, 1 bit: instruction-memory request valid.
REQ-004 The block SHALL have port ireq_addr, output, 32 bits: instruction-memory request address.
REQ-005 The block SHALL have port ireq_addr_ok, input, 1 bit: memory accepted the request this cycle.
REQ-006 The block SHALL have port ireq_data_ok, input, 1 bit: response data valid this cycle.
REQ-007 The block SHALL have port ireq_data, input, 32 bits: response instruction word.
REQ-008 The block SHALL have port fetch_valid, output, 1 bit: queue head holds a valid instruction for decode.
REQ-009 The block SHALL have port fetch_instr, output, 32 bits: head instruction.
REQ-010 The block SHALL have port fetch_pc, output, 32 bits: head instruction address.
REQ-011 The block SHALL have port fetch_ready, input, 1 bit: decode consumes the head when fetch_valid is also 1.
REQ-012 The block SHALL have port redirect_valid, input, 1 bit: branch/jump taken; refetch from redirect_pc.
REQ-013 The block SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-014 The block SHALL have port fetch_adel, output, 1 bit: head entry is a misaligned-fetch marker (exists only with FETCH_ALIGN_CHECK_EN).
REQ-015 The block SHALL have parameter RESET_PC, default 32'hBFC0_0000: first fetch address.

Function
REQ-016 The request FSM SHALL have states IDLE (no request outstanding), REQ (ireq_valid=1, awaiting addr_ok) and WAIT (accepted, awaiting data_ok), plus a 1-bit drop flag.
REQ-017 IDLE->REQ SHALL occur when queue_count + outstanding < 2; ireq_addr = pc; ireq_valid is registered.
REQ-018 In REQ, ireq_valid and ireq_addr SHALL hold stable until ireq_addr_ok; on addr_ok: ->WAIT, pc <= pc + 4 (32-bit wrap).
REQ-019 In WAIT on data_ok: if drop=0, push {ireq_data, request addr} into the queue; if drop=1, discard and clear drop; in both cases ->IDLE, or ->REQ if space remains.
REQ-020 At most one request SHALL be outstanding; data_ok outside WAIT SHALL be ignored.
REQ-021 The queue SHALL be a 2-entry FIFO; a pushed entry is visible on fetch_* the cycle after data_ok (1-cycle latency).
REQ-022 Pop SHALL occur when fetch_valid && fetch_ready; push and pop in the same cycle with count=2 is impossible by REQ-017; with count=1 the count stays 1.
REQ-023 On redirect_valid: pc <= redirect_pc; all queue entries not popped this cycle SHALL be flushed; a same-cycle pop still completes.
REQ-024 On redirect in WAIT, or in REQ (the request is still held until addr_ok), drop SHALL be set so the stale response is discarded; a same-cycle data_ok is discarded.
REQ-025 On redirect in REQ, the request after the stale one SHALL use redirect_pc.
REQ-026 A redirect while drop=1 SHALL keep drop=1 and update pc only.
REQ-027 fetch_instr and fetch_pc SHALL be don't-care when fetch_valid=0.

Reset
REQ-028 While resetn=0: state=IDLE, drop=0, queue empty, pc=RESET_PC, ireq_valid=0, ireq_addr=RESET_PC, fetch_valid=0, fetch_instr=0, fetch_pc=0, fetch_adel=0.
REQ-029 ireq_valid SHALL first assert on the first rising edge after resetn deasserts.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a data_ok during or after reset, with the FSM in IDLE, is ignored.

Configuration
REQ-031 With FETCH_ALIGN_CHECK_EN defined: if pc[1:0] != 0 when a request would issue, no memory request is made; instead an entry {instr=0, pc, adel=1} is pushed the same cycle, and further fetch stalls until a redirect.
REQ-032 Without FETCH_ALIGN_CHECK_EN: no alignment check, the fetch_adel port does not exist, and ireq_addr = pc unmodified.

Verification
REQ-033 Reset release, addr_ok and data_ok immediate, data 0x24080001 -> ireq_addr 0xBFC00000, then fetch_valid=1, fetch_pc=0xBFC00000 next cycle.
REQ-034 fetch_ready=0 for 10 cycles -> exactly 2 entries (0xBFC00000, 0xBFC00004) queued; ireq_valid stays 0 until a pop.
REQ-035 redirect_valid=1 with redirect_pc=0x80001000 while in WAIT, data_ok next cycle -> that data is discarded; the next ireq_addr is 0x80001000.
REQ-036 redirect in the same cycle as data_ok, with 1 entry popped that cycle -> queue empty next cycle, fetch_valid=0.
REQ-037 resetn pulsed low while in WAIT -> all outputs at reset values; a later stray data_ok does not set fetch_valid.
REQ-038 With FETCH_ALIGN_CHECK_EN, redirect_pc=0x80000002 -> no ireq_valid; fetch_adel=1, fetch_pc=0x80000002.
